pixel_color_arbiter: RTL and testbench
======================================

// Module: pixel_color_arbiter
// PURPOSE
//  Shares the single 3-bit pixel colour channel among NUM_LAYERS drawing requesters
//  (score, paddles, ball, ...) plus a background, one pixel per i_pixel_refresh strobe.
//  Fixed-priority compositor with a game-mode FSM (NORMAL/FLASH/PAUSE) applied per frame.
//  Sits between the object renderers and color_Splitter; o_color drives its i_color.
// PARAMETERS
//  NUM_LAYERS    4   number of requesters; layer 0 = highest priority
//  COLOR_W       3   colour width, {R,G,B}
//  FLASH_FRAMES  30  frames the FLASH mode lasts after a goal (1..255)
// PORTS
//  i_clock         in   1                    system clock
//  i_reset_n       in   1                    async active-low reset
//  i_pixel_refresh in   1                    pixel strobe; all pixel-path regs advance only when 1
//  i_video_on      in   1                    1 = visible area, 0 = blanking
//  i_frame_start   in   1                    1-clock pulse at first pixel of frame
//  i_layer_req     in   NUM_LAYERS           per-layer "pixel covered" request
//  i_layer_color   in   NUM_LAYERS*COLOR_W   layer k colour at [k*COLOR_W +: COLOR_W]
//  i_bg_color      in   COLOR_W              colour when no layer granted
//  i_goal          in   1                    1-clock pulse: goal scored
//  i_pause_toggle  in   1                    1-clock pulse: toggle pause
//  o_color         out  COLOR_W              registered composited pixel colour
//  o_layer_grant   out  NUM_LAYERS           registered one-hot winner (0 if bg/blank)
//  o_mode          out  2                    current FSM mode (00 NORMAL,01 FLASH,10 PAUSE)
//  o_busy          out  1                    1 while mode == FLASH
// BEHAVIOUR
//  Reset (async, i_reset_n=0): o_color=0, o_layer_grant=0, mode=frame_mode=NORMAL,
//   flash_cnt=0, o_busy=0. Takes effect immediately, mid-pixel or mid-frame.
//  Pixel path (latency 1 strobe): on clock edge with i_pixel_refresh=1, register result
//   from inputs sampled that edge; o_color/o_layer_grant hold when strobe=0.
//  Arbitration: eligible = i_layer_req masked by frame_mode; grant = lowest-index eligible.
//   PAUSE: eligible = i_layer_req & 1 (only layer 0). NORMAL/FLASH: eligible = i_layer_req.
//   colour = granted layer colour, else i_bg_color.
//  FLASH: if flash_cnt[2]==1, colour is inverted (~colour); grant unchanged.
//  Blanking: i_video_on=0 at strobe -> o_color=0, o_layer_grant=0 regardless of mode.
//  Mode FSM (updates every clock, independent of strobe):
//   NORMAL: i_goal -> FLASH, flash_cnt<=FLASH_FRAMES; else i_pause_toggle -> PAUSE.
//   FLASH : i_goal -> reload flash_cnt<=FLASH_FRAMES; else i_frame_start decrements;
//           i_frame_start with flash_cnt==1 -> NORMAL, flash_cnt<=0. i_pause_toggle ignored.
//   PAUSE : i_pause_toggle -> NORMAL; i_goal ignored.
//   Simultaneous goal+pause in NORMAL: goal wins. Encoding 11 unreachable -> NORMAL.
//  frame_mode <= mode on i_frame_start only (no mid-frame tearing); frame_start and a
//   mode change on the same edge: frame_mode takes the pre-change mode.
//  flash_cnt is 8 bits; never wraps below 0.
// STRUCTURE
//  Shared header pong_defs.vh: MODE_NORMAL/MODE_FLASH/MODE_PAUSE encodings, COLOR_W,
//   colour constants (COLOR_BLACK 3'b000, COLOR_WHITE 3'b111).
//  One sub-module: pixel_priority_encoder (combinational, NUM_LAYERS req -> one-hot grant
//   + valid). FSM and pixel register stage stay in this module.
// TESTING
//  1 Reset: assert i_reset_n=0 mid-frame with o_color=3'b101 -> o_color=0, grant=0, mode=00 at once.
//  2 Priority: req=4'b1010, colors L1=3'b010,L3=3'b100, video_on, strobe -> next edge o_color=010,
//    grant=0010; req=0, bg=3'b001 -> o_color=001, grant=0; strobe=0 -> outputs hold.
//  3 Blanking: req=4'b0001, i_video_on=0 -> o_color=000, grant=0000.
//  4 Goal/flash: i_goal in NORMAL -> o_mode=01, o_busy=1; after next frame_start, frames with
//    flash_cnt[2]=1 show ~colour (010->101); after FLASH_FRAMES=30 frame_starts -> o_mode=00.
//  5 Pause: toggle -> o_mode=10 immediately, masking from next frame_start: req=4'b0110 -> bg
//    colour, grant=0; i_goal ignored; toggle again -> 00; goal+toggle same cycle in NORMAL -> 01.
//  6 Retrigger: i_goal during FLASH at flash_cnt=5 -> flash_cnt=30, mode stays 01.

Source files
------------

// File: rtl/pixel_color_arbiter_pkg.sv
// pixel_color_arbiter_pkg: shared mode encodings and colour width for the pong compositor
package pixel_color_arbiter_pkg;
  localparam int DEF_COLOR_W = 3;
  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_FLASH  = 2'b01,
    MODE_PAUSE  = 2'b10
  } mode_t;
endpackage

// File: rtl/pixel_color_arbiter_pixel_priority_encoder.sv
// pixel_priority_encoder: lowest-index request wins, one-hot grant plus valid
module pixel_priority_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_valid
);
  // isolating the lowest set bit gives the highest-priority requester directly
  assign o_grant = i_req & (~i_req + N'(1));
  assign o_valid = |i_req;
endmodule

// File: rtl/pixel_color_arbiter.sv
// pixel_color_arbiter: fixed-priority pixel compositor with per-frame NORMAL/FLASH/PAUSE mode
import pixel_color_arbiter_pkg::*;
module pixel_color_arbiter #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_pixel_refresh,
  input  logic                          i_video_on,
  input  logic                          i_frame_start,
  input  logic [NUM_LAYERS-1:0]         i_layer_req,
  input  logic [NUM_LAYERS*COLOR_W-1:0] i_layer_color,
  input  logic [COLOR_W-1:0]            i_bg_color,
  input  logic                          i_goal,
  input  logic                          i_pause_toggle,
  output logic [COLOR_W-1:0]            o_color,
  output logic [NUM_LAYERS-1:0]         o_layer_grant,
  output logic [1:0]                    o_mode,
  output logic                          o_busy
);
  localparam logic [7:0] FLASH_CNT = 8'(FLASH_FRAMES);
  mode_t                   r_mode, r_frame_mode, w_mode_nxt;
  logic [7:0]              r_flash_cnt, w_cnt_nxt;
  logic [COLOR_W-1:0]      r_color, w_sel, w_base, w_color;
  logic [NUM_LAYERS-1:0]   r_grant, w_elig, w_grant;
  logic                    w_valid;
  always_comb begin
    w_mode_nxt = r_mode;
    w_cnt_nxt  = r_flash_cnt;
    case (r_mode)
      MODE_NORMAL:
        if (i_goal) begin
          w_mode_nxt = MODE_FLASH;
          w_cnt_nxt  = FLASH_CNT;
        end else if (i_pause_toggle) w_mode_nxt = MODE_PAUSE;
      MODE_FLASH:
        if (i_goal) w_cnt_nxt = FLASH_CNT;
        else if (i_frame_start) begin
          w_mode_nxt = (r_flash_cnt <= 8'd1) ? MODE_NORMAL : MODE_FLASH;
          w_cnt_nxt  = (r_flash_cnt <= 8'd1) ? 8'd0 : r_flash_cnt - 8'd1;
        end
      MODE_PAUSE:
        if (i_pause_toggle) w_mode_nxt = MODE_NORMAL;
      default: w_mode_nxt = MODE_NORMAL;
    endcase
  end
  // masking follows the mode latched at frame start so a frame never tears
  assign w_elig = (r_frame_mode == MODE_PAUSE) ? {{(NUM_LAYERS-1){1'b0}}, i_layer_req[0]} : i_layer_req;
  pixel_priority_encoder #(.N(NUM_LAYERS)) u_prio (
    .i_req   (w_elig),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_LAYERS; k++)
      w_sel = w_sel | (w_grant[k] ? i_layer_color[k*COLOR_W +: COLOR_W] : '0);
  end
  assign w_base  = w_valid ? w_sel : i_bg_color;
  assign w_color = (r_frame_mode == MODE_FLASH && r_flash_cnt[2]) ? ~w_base : w_base;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mode       <= MODE_NORMAL;
      r_frame_mode <= MODE_NORMAL;
      r_flash_cnt  <= '0;
      r_color      <= '0;
      r_grant      <= '0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_flash_cnt <= w_cnt_nxt;
      if (i_frame_start) r_frame_mode <= r_mode;
      if (i_pixel_refresh) begin
        r_color <= i_video_on ? w_color : '0;
        r_grant <= i_video_on ? w_grant : '0;
      end
    end
  end
  assign o_color       = r_color;
  assign o_layer_grant = r_grant;
  assign o_mode        = r_mode;
  assign o_busy        = (r_mode == MODE_FLASH);
endmodule

// File: tb/tb_pixel_color_arbiter.sv
// tb_pixel_color_arbiter: table vectors plus scoreboarded mode sequences for pixel_color_arbiter
module tb_pixel_color_arbiter;
  logic        clk = 0;
  logic        rst_n;
  logic        stb, vid, fs, goal, pt;
  logic [3:0]  req;
  logic [11:0] lcol;
  logic [2:0]  bg;
  logic [2:0]  o_color;
  logic [3:0]  o_grant;
  logic [1:0]  o_mode;
  logic        o_busy;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [1:0]  m_mode, m_fm;
  logic [7:0]  m_cnt;
  logic [2:0]  h_c;
  logic [3:0]  h_g;
  logic [6:0]  sb[$];

  typedef struct {
    logic [3:0] req;
    logic [2:0] bg;
    logic       vid;
    logic       stb;
    logic [2:0] ec;
    logic [3:0] eg;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  pixel_color_arbiter dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_pixel_refresh (stb),
    .i_video_on      (vid),
    .i_frame_start   (fs),
    .i_layer_req     (req),
    .i_layer_color   (lcol),
    .i_bg_color      (bg),
    .i_goal          (goal),
    .i_pause_toggle  (pt),
    .o_color         (o_color),
    .o_layer_grant   (o_grant),
    .o_mode          (o_mode),
    .o_busy          (o_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: scan from the top so the last hit is the lowest index
  function automatic logic [6:0] pix(input logic [3:0] r, input logic [2:0] b, input logic v);
    logic [3:0] el;
    logic [2:0] c;
    logic [3:0] g;
    if (!v) return 7'd0;
    el = (m_fm == 2'b10) ? (r & 4'b0001) : r;
    c = b;
    g = 4'd0;
    for (int k = 3; k >= 0; k--)
      if (el[k]) begin
        g = 4'd1 << k;
        c = lcol[k*3 +: 3];
      end
    if (m_fm == 2'b01 && m_cnt[2]) c = ~c;
    return {c, g};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fm = 0; m_cnt = 0; h_c = 0; h_g = 0;
    sb.delete();
  endtask

  task automatic cyc(input logic [3:0] r, input logic [2:0] b, input logic v, input logic s,
                     input logic f, input logic g, input logic p);
    logic [6:0] e;
    req = r; bg = b; vid = v; stb = s; fs = f; goal = g; pt = p;
    if (s) {h_c, h_g} = pix(r, b, v);
    sb.push_back({h_c, h_g});
    if (f) m_fm = m_mode;
    case (m_mode)
      2'b00: if (g) begin m_mode = 2'b01; m_cnt = 8'd30; end else if (p) m_mode = 2'b10;
      2'b01: if (g) m_cnt = 8'd30;
             else if (f) begin
               if (m_cnt == 8'd1) begin m_mode = 2'b00; m_cnt = 8'd0; end
               else m_cnt = m_cnt - 8'd1;
             end
      2'b10: if (p) m_mode = 2'b00;
      default: m_mode = 2'b00;
    endcase
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pixel", 32'({o_color, o_grant}), 32'(e));
    chk("mode", 32'(o_mode), 32'(m_mode));
    chk("busy", 32'(o_busy), 32'(m_mode == 2'b01));
    fs = 0; goal = 0; pt = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(4'b0010, 3'b001, 1, 1, 1, 0, 0);
      cyc(4'b0010, 3'b001, 1, 1, 0, 0, 0);
      cyc(4'b0010, 3'b001, 1, 1, 0, 0, 0);
    end
  endtask

  initial begin
    tbl[0] = '{4'b1010, 3'b001, 1, 1, 3'b010, 4'b0010};
    tbl[1] = '{4'b0000, 3'b001, 1, 1, 3'b001, 4'b0000};
    tbl[2] = '{4'b0000, 3'b001, 1, 0, 3'b001, 4'b0000};
    tbl[3] = '{4'b0001, 3'b001, 0, 1, 3'b000, 4'b0000};
    tbl[4] = '{4'b1111, 3'b001, 1, 1, 3'b111, 4'b0001};
    tbl[5] = '{4'b1000, 3'b001, 1, 1, 3'b100, 4'b1000};
    tbl[6] = '{4'b1100, 3'b001, 1, 1, 3'b011, 4'b0100};
    tbl[7] = '{4'b0110, 3'b001, 1, 1, 3'b010, 4'b0010};
    tbl[8] = '{4'b1000, 3'b001, 1, 0, 3'b010, 4'b0010};
    tbl[9] = '{4'b0001, 3'b110, 1, 1, 3'b111, 4'b0001};
    lcol = {3'b100, 3'b011, 3'b010, 3'b111};
    rst_n = 0; stb = 0; vid = 0; fs = 0; goal = 0; pt = 0; req = 0; bg = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_color", 32'(o_color), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_mode", 32'(o_mode), 0);
    #4 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].req, tbl[i].bg, tbl[i].vid, tbl[i].stb, 0, 0, 0);
      chk($sformatf("tbl%0d", i), 32'({o_color, o_grant}), 32'({tbl[i].ec, tbl[i].eg}));
    end
    cyc(4'b0010, 3'b001, 1, 0, 0, 1, 0);
    chk("goal_mode", 32'(o_mode), 1);
    frames(1);
    chk("flash_inv", 32'(o_color), 32'(3'b101));
    cyc(4'b0010, 3'b001, 1, 1, 0, 0, 1);
    frames(24);
    chk("flash_cnt5", 32'(o_mode), 1);
    cyc(4'b0010, 3'b001, 1, 1, 0, 1, 0);
    frames(29);
    chk("retrig_29", 32'(o_mode), 1);
    frames(1);
    chk("retrig_30", 32'(o_mode), 0);
    cyc(4'b0010, 3'b001, 1, 1, 0, 1, 0);
    frames(29);
    chk("flash_29", 32'(o_busy), 1);
    frames(1);
    chk("flash_30", 32'(o_mode), 0);
    frames(1);
    cyc(4'b0110, 3'b001, 1, 1, 0, 0, 1);
    chk("pause_now", 32'(o_mode), 2);
    cyc(4'b0110, 3'b001, 1, 1, 0, 0, 0);
    chk("pause_prefs", 32'(o_grant), 32'(4'b0010));
    cyc(4'b0110, 3'b001, 1, 1, 1, 0, 0);
    cyc(4'b0110, 3'b001, 1, 1, 0, 0, 0);
    chk("pause_mask", 32'({o_color, o_grant}), 32'({3'b001, 4'b0000}));
    cyc(4'b0110, 3'b001, 1, 1, 0, 1, 0);
    chk("pause_goal", 32'(o_mode), 2);
    cyc(4'b0111, 3'b001, 1, 1, 0, 0, 0);
    chk("pause_l0", 32'({o_color, o_grant}), 32'({3'b111, 4'b0001}));
    cyc(4'b0111, 3'b001, 1, 1, 0, 0, 1);
    chk("unpause", 32'(o_mode), 0);
    cyc(4'b0111, 3'b001, 1, 1, 0, 1, 1);
    chk("goal_wins", 32'(o_mode), 1);
    cyc(4'b0000, 3'b101, 1, 1, 0, 0, 0);
    chk("pre_rst", 32'(o_color), 32'(3'b101));
    #2 rst_n = 0;
    #1;
    chk("arst_color", 32'(o_color), 0);
    chk("arst_grant", 32'(o_grant), 0);
    chk("arst_mode", 32'(o_mode), 0);
    chk("arst_busy", 32'(o_busy), 0);
    model_reset();
    #1 rst_n = 1;
    @(posedge clk); #1;
    cyc(4'b0010, 3'b001, 1, 1, 1, 0, 0);
    cyc(4'b0010, 3'b001, 1, 1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
